// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: mode encodings, mode bit positions
// and the frame state enumeration.
package spi_pkg;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spiState_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with single-cycle
// rise/fall strobes derived from the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Shift the pin through the synchroniser and remember the last settled level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// Parametrised SPI slave: oversamples SCLK/CS/MOSI in the system clock
// domain, supports all four CPOL/CPHA modes latched per frame, and offers
// valid/ready RX and TX word streams with overrun/underrun/abort reporting.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter int                SYNC_STAGES   = 2,
  parameter int                LSB_FIRST     = 0,
  parameter int                RX_OVERWRITE  = 0,
  parameter logic [DATA_W-1:0] UNDERRUN_FILL = DATA_W'(8'hFF)
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic              frame_active_o,
  output logic              frame_abort_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam bit LSB   = (LSB_FIRST != 0);
  localparam bit OVWR  = (RX_OVERWRITE != 0);

  logic sclkSync, sclkRise, sclkFall;
  logic csSync, csRise, csFall;
  logic [SYNC_STAGES-1:0] mosiChain_q;
  logic mosiSync;

  spiState_e state_q, state_d;
  logic frameActive, startFrame, endFrame;

  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] rxShift_q, rxShift_d;
  logic [DATA_W-1:0] txShift_q, txShift_d;
  logic              wordDone_q, wordDone_d;
  logic              holdFirst_q, holdFirst_d;
  logic [DATA_W-1:0] rxData_q, rxData_d;
  logic              rxValid_q, rxValid_d;
  logic              rxOverrun_q, rxOverrun_d;
  logic [DATA_W-1:0] txHold_q, txHold_d;
  logic              txFull_q, txFull_d;
  logic              txUnderrun_q, txUnderrun_d;
  logic              frameAbort_q, frameAbort_d;

  logic edgeEn, anyEdge, leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic [DATA_W-1:0] rxNext, txShifted;
  logic rxTransfer, txLoad, wordComplete, reload;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) sclkSyncInst (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .async_i (spi_clk_i),
    .sync_o  (sclkSync),
    .rise_o  (sclkRise),
    .fall_o  (sclkFall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) csSyncInst (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .async_i (spi_cs_i),
    .sync_o  (csSync),
    .rise_o  (csRise),
    .fall_o  (csFall)
  );

  // MOSI only needs a level synchroniser matched in depth to SCLK
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      mosiChain_q <= '0;
    end else begin
      mosiChain_q <= {mosiChain_q[SYNC_STAGES-2:0], spi_mosi_i};
    end
  end

  assign mosiSync = mosiChain_q[SYNC_STAGES-1];

  // Frame state register
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame starts on a synchronised CS fall and ends on a CS rise
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (csFall) state_d = ACTIVE;
      ACTIVE:  if (csRise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode frame entry/exit events from the current state
  always_comb begin
    frameActive = (state_q == ACTIVE);
    startFrame  = (state_q == IDLE) && csFall;
    endFrame    = (state_q == ACTIVE) && csRise;
  end

  // A leading edge moves SCLK away from its CPOL idle level
  assign edgeEn     = frameActive & ~csSync;
  assign anyEdge    = edgeEn & (sclkRise | sclkFall);
  assign leadEdge   = anyEdge & (sclkSync != mode_q[CPOL_BIT]);
  assign trailEdge  = anyEdge & (sclkSync == mode_q[CPOL_BIT]);
  assign sampleEdge = mode_q[CPHA_BIT] ? trailEdge : leadEdge;
  assign shiftEdge  = mode_q[CPHA_BIT] ? leadEdge : trailEdge;

  assign rxNext    = LSB ? {mosiSync, rxShift_q[DATA_W-1:1]} : {rxShift_q[DATA_W-2:0], mosiSync};
  assign txShifted = LSB ? {1'b0, txShift_q[DATA_W-1:1]} : {txShift_q[DATA_W-2:0], 1'b0};

  assign rxTransfer   = rxValid_q & rx_ready_i;
  assign txLoad       = tx_valid_i & ~txFull_q;
  assign wordComplete = sampleEdge && (bitCnt_q == CNT_W'(DATA_W - 1));
  assign reload       = startFrame | (shiftEdge & wordDone_q & ~holdFirst_q);

  // Shifters, bit counter, RX buffer and TX holding register next state
  always_comb begin
    mode_d       = mode_q;
    bitCnt_d     = bitCnt_q;
    rxShift_d    = rxShift_q;
    txShift_d    = txShift_q;
    wordDone_d   = wordDone_q;
    holdFirst_d  = holdFirst_q;
    rxData_d     = rxData_q;
    rxValid_d    = rxValid_q;
    rxOverrun_d  = 1'b0;
    txHold_d     = txHold_q;
    txFull_d     = txFull_q;
    txUnderrun_d = 1'b0;
    frameAbort_d = 1'b0;

    if (endFrame) begin
      frameAbort_d = (bitCnt_q != '0);
      bitCnt_d     = '0;
      rxShift_d    = '0;
      txShift_d    = '0;
      wordDone_d   = 1'b0;
      holdFirst_d  = 1'b0;
    end else begin
      if (startFrame) begin
        mode_d      = mode_i;
        bitCnt_d    = '0;
        rxShift_d   = '0;
        wordDone_d  = 1'b0;
        holdFirst_d = mode_i[CPHA_BIT];
      end
      if (sampleEdge) begin
        rxShift_d = rxNext;
        if (wordComplete) begin
          bitCnt_d   = '0;
          wordDone_d = 1'b1;
        end else begin
          bitCnt_d = bitCnt_q + CNT_W'(1);
        end
      end
      if (shiftEdge) begin
        if (holdFirst_q) begin
          holdFirst_d = 1'b0;
        end else if (wordDone_q) begin
          wordDone_d = 1'b0;
        end else begin
          txShift_d = txShifted;
        end
      end
    end

    if (reload) begin
      if (txFull_q) begin
        txShift_d = txHold_q;
        txFull_d  = 1'b0;
      end else begin
        txShift_d    = UNDERRUN_FILL;
        txUnderrun_d = 1'b1;
      end
    end
    if (txLoad) begin
      txHold_d = tx_data_i;
      txFull_d = 1'b1;
    end

    if (rxTransfer) begin
      rxValid_d = 1'b0;
    end
    if (wordComplete) begin
      if (!rxValid_q || rxTransfer) begin
        rxData_d  = rxNext;
        rxValid_d = 1'b1;
      end else begin
        rxOverrun_d = 1'b1;
        if (OVWR) begin
          rxData_d = rxNext;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      mode_q       <= MODE0;
      bitCnt_q     <= '0;
      rxShift_q    <= '0;
      txShift_q    <= '0;
      wordDone_q   <= 1'b0;
      holdFirst_q  <= 1'b0;
      rxData_q     <= '0;
      rxValid_q    <= 1'b0;
      rxOverrun_q  <= 1'b0;
      txHold_q     <= '0;
      txFull_q     <= 1'b0;
      txUnderrun_q <= 1'b0;
      frameAbort_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      bitCnt_q     <= bitCnt_d;
      rxShift_q    <= rxShift_d;
      txShift_q    <= txShift_d;
      wordDone_q   <= wordDone_d;
      holdFirst_q  <= holdFirst_d;
      rxData_q     <= rxData_d;
      rxValid_q    <= rxValid_d;
      rxOverrun_q  <= rxOverrun_d;
      txHold_q     <= txHold_d;
      txFull_q     <= txFull_d;
      txUnderrun_q <= txUnderrun_d;
      frameAbort_q <= frameAbort_d;
    end
  end

  assign spi_miso_o     = frameActive & (LSB ? txShift_q[0] : txShift_q[DATA_W-1]);
  assign spi_miso_oe_o  = frameActive;
  assign frame_active_o = frameActive;
  assign rx_data_o      = rxData_q;
  assign rx_valid_o     = rxValid_q;
  assign rx_overrun_o   = rxOverrun_q;
  assign tx_ready_o     = ~txFull_q;
  assign tx_underrun_o  = txUnderrun_q;
  assign frame_abort_o  = frameAbort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: an 8-bit drop-word instance and a
// 16-bit overwrite instance share SCLK/MOSI/mode, each with its own CS.
module tb_spi_slave_core;
  import spi_pkg::*;

  logic sysClk = 1'b0;
  logic sysRst = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs8 = 1'b1;
  logic cs16 = 1'b1;
  logic [1:0] mode = MODE0;

  logic miso8, oe8, rxValid8, ovr8, txReady8, und8, act8, abort8;
  logic [7:0] rxData8;
  logic rxReady8 = 1'b1;
  logic [7:0] txData8 = '0;
  logic txValid8 = 1'b0;

  logic miso16, oe16, rxValid16, ovr16, txReady16, und16, act16, abort16;
  logic [15:0] rxData16;
  logic rxReady16 = 1'b1;
  logic [15:0] txData16 = '0;
  logic txValid16 = 1'b0;

  int vecCount = 0;
  int failCount = 0;
  int ovrCnt8 = 0, undCnt8 = 0, abtCnt8 = 0, ovrCnt16 = 0;
  logic [31:0] rxExp8[$];
  logic [31:0] rxExp16[$];

  typedef struct {
    logic [1:0] mode;
    bit         preload;
    logic [7:0] txWord;
    logic [7:0] mosiWord;
    logic [7:0] expMiso;
    int         expUnder;
  } vec_t;

  vec_t vecs[6];

  // 50 MHz-class system clock
  always #10 sysClk = ~sysClk;

  spi_slave_core #(.DATA_W(8), .RX_OVERWRITE(0)) dut8 (
    .sys_clk_i(sysClk), .sys_rst_i(sysRst), .spi_clk_i(sclk), .spi_cs_i(cs8),
    .spi_mosi_i(mosi), .spi_miso_o(miso8), .spi_miso_oe_o(oe8), .mode_i(mode),
    .rx_data_o(rxData8), .rx_valid_o(rxValid8), .rx_ready_i(rxReady8),
    .rx_overrun_o(ovr8), .tx_data_i(txData8), .tx_valid_i(txValid8),
    .tx_ready_o(txReady8), .tx_underrun_o(und8), .frame_active_o(act8),
    .frame_abort_o(abort8)
  );

  spi_slave_core #(.DATA_W(16), .RX_OVERWRITE(1)) dut16 (
    .sys_clk_i(sysClk), .sys_rst_i(sysRst), .spi_clk_i(sclk), .spi_cs_i(cs16),
    .spi_mosi_i(mosi), .spi_miso_o(miso16), .spi_miso_oe_o(oe16), .mode_i(mode),
    .rx_data_o(rxData16), .rx_valid_o(rxValid16), .rx_ready_i(rxReady16),
    .rx_overrun_o(ovr16), .tx_data_i(txData16), .tx_valid_i(txValid16),
    .tx_ready_o(txReady16), .tx_underrun_o(und16), .frame_active_o(act16),
    .frame_abort_o(abort16)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Count single-cycle status pulses away from the active edge
  always @(negedge sysClk) begin
    if (ovr8) ovrCnt8++;
    if (und8) undCnt8++;
    if (abort8) abtCnt8++;
    if (ovr16) ovrCnt16++;
  end

  // Scoreboard: pop and compare every RX handshake of the 8-bit instance
  always @(negedge sysClk) begin
    if (!sysRst && rxValid8 && rxReady8) begin
      if (rxExp8.size() == 0) begin
        vecCount++;
        failCount++;
        $display("[TB] FAIL rx8 unexpected word: got %h, expected none", rxData8);
      end else begin
        checkOutput("rx8 word", {24'h0, rxData8}, rxExp8.pop_front());
      end
    end
  end

  // Scoreboard: pop and compare every RX handshake of the 16-bit instance
  always @(negedge sysClk) begin
    if (!sysRst && rxValid16 && rxReady16) begin
      if (rxExp16.size() == 0) begin
        vecCount++;
        failCount++;
        $display("[TB] FAIL rx16 unexpected word: got %h, expected none", rxData16);
      end else begin
        checkOutput("rx16 word", {16'h0, rxData16}, rxExp16.pop_front());
      end
    end
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] stat8();
    return {act8, oe8, miso8, rxValid8, txReady8, ovr8, und8, abort8, 16'h0, rxData8};
  endfunction

  function automatic logic [31:0] stat16();
    return {act16, oe16, miso16, rxValid16, txReady16, ovr16, und16, abort16, 8'h0, rxData16};
  endfunction

  task automatic setMode(input logic [1:0] m);
    mode = m;
    sclk = m[CPOL_BIT];
    #200;
  endtask

  task automatic csAssert(input int which);
    if (which == 8) cs8 = 1'b0;
    else cs16 = 1'b0;
    #500;
  endtask

  task automatic csRelease(input int which);
    #500;
    if (which == 8) cs8 = 1'b1;
    else cs16 = 1'b1;
    #1000;
  endtask

  task automatic setReady(input int which, input logic v);
    @(posedge sysClk);
    #1;
    if (which == 8) rxReady8 = v;
    else rxReady16 = v;
  endtask

  task automatic loadTx8(input logic [7:0] w);
    @(posedge sysClk);
    #1 txData8 = w;
    txValid8 = 1'b1;
    @(posedge sysClk);
    #1 txValid8 = 1'b0;
    checkOutput("tx8 holding full", {31'h0, txReady8}, 32'h0);
  endtask

  task automatic loadTx16(input logic [15:0] w);
    @(posedge sysClk);
    #1 txData16 = w;
    txValid16 = 1'b1;
    @(posedge sysClk);
    #1 txValid16 = 1'b0;
    checkOutput("tx16 holding full", {31'h0, txReady16}, 32'h0);
  endtask

  task automatic drain(input int which);
    repeat (40) @(negedge sysClk);
    if (which == 8) checkOutput("rx8 scoreboard drained", rxExp8.size(), 32'h0);
    else checkOutput("rx16 scoreboard drained", rxExp16.size(), 32'h0);
  endtask

  // Master: shift nBits of outWord (MSB-first from bit w-1), capture MISO
  task automatic spiShift(input int which, input int w, input int nBits,
                          input logic [31:0] outWord, output logic [31:0] inWord);
    logic misoBit;
    inWord = '0;
    for (int i = 0; i < nBits; i++) begin
      if (mode[CPHA_BIT] == 1'b0) begin
        mosi = outWord[w-1-i];
        #250;
        misoBit = (which == 8) ? miso8 : miso16;
        sclk = ~mode[CPOL_BIT];
        #500;
        sclk = mode[CPOL_BIT];
        #250;
      end else begin
        sclk = ~mode[CPOL_BIT];
        mosi = outWord[w-1-i];
        #500;
        misoBit = (which == 8) ? miso8 : miso16;
        sclk = mode[CPOL_BIT];
        #500;
      end
      inWord = {inWord[30:0], misoBit};
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] got;
    int u0, a0, o0;
    setMode(v.mode);
    if (v.preload) loadTx8(v.txWord);
    u0 = undCnt8;
    a0 = abtCnt8;
    o0 = ovrCnt8;
    rxExp8.push_back({24'h0, v.mosiWord});
    csAssert(8);
    spiShift(8, 8, 8, {24'h0, v.mosiWord}, got);
    csRelease(8);
    drain(8);
    checkOutput($sformatf("vec%0d miso", idx), got, {24'h0, v.expMiso});
    checkOutput($sformatf("vec%0d underruns", idx), undCnt8 - u0, v.expUnder);
    checkOutput($sformatf("vec%0d aborts+overruns", idx), (abtCnt8 - a0) + (ovrCnt8 - o0), 32'h0);
  endtask

  initial begin
    logic [31:0] got;
    int u0, a0, o0;

    vecs[0] = '{mode: MODE0, preload: 1'b1, txWord: 8'h96, mosiWord: 8'hC0, expMiso: 8'h96, expUnder: 1};
    vecs[1] = '{mode: MODE1, preload: 1'b0, txWord: 8'h00, mosiWord: 8'hAA, expMiso: 8'hFF, expUnder: 1};
    vecs[2] = '{mode: MODE2, preload: 1'b1, txWord: 8'h5A, mosiWord: 8'h01, expMiso: 8'h5A, expUnder: 1};
    vecs[3] = '{mode: MODE3, preload: 1'b1, txWord: 8'h81, mosiWord: 8'h7E, expMiso: 8'h81, expUnder: 0};
    vecs[4] = '{mode: MODE0, preload: 1'b0, txWord: 8'h00, mosiWord: 8'h00, expMiso: 8'hFF, expUnder: 2};
    vecs[5] = '{mode: MODE3, preload: 1'b0, txWord: 8'h00, mosiWord: 8'hFF, expMiso: 8'hFF, expUnder: 1};

    // Reset state
    #55;
    checkOutput("reset state dut8", stat8(), 32'h0800_0000);
    checkOutput("reset state dut16", stat16(), 32'h0800_0000);
    sysRst = 1'b0;
    repeat (10) @(negedge sysClk);
    checkOutput("idle after reset dut8", stat8(), 32'h0800_0000);

    // Table-driven single-word frames across all modes
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Two words with a long idle gap inside one mode-0 frame
    setMode(MODE0);
    a0 = abtCnt8;
    o0 = ovrCnt8;
    rxExp8.push_back(32'hC0);
    rxExp8.push_back(32'hAA);
    csAssert(8);
    spiShift(8, 8, 8, 32'hC0, got);
    #10000;
    spiShift(8, 8, 8, 32'hAA, got);
    csRelease(8);
    drain(8);
    checkOutput("gap frame overruns", ovrCnt8 - o0, 32'h0);
    checkOutput("gap frame aborts", abtCnt8 - a0, 32'h0);

    // Mode 3, 16-bit, preloaded TX word
    setMode(MODE3);
    loadTx16(16'h1234);
    rxExp16.push_back(32'hA55A);
    csAssert(16);
    checkOutput("tx16 ready at CS fall", {31'h0, txReady16}, 32'h1);
    spiShift(16, 16, 16, 32'hA55A, got);
    csRelease(16);
    drain(16);
    checkOutput("mode3 miso16", got, 32'h1234);

    // Overrun with consumer stalled: drop on dut8, overwrite on dut16
    setMode(MODE0);
    setReady(8, 1'b0);
    setReady(16, 1'b0);
    o0 = ovrCnt8;
    csAssert(8);
    spiShift(8, 8, 8, 32'h11, got);
    spiShift(8, 8, 8, 32'h22, got);
    csRelease(8);
    checkOutput("overrun8 pulses", ovrCnt8 - o0, 32'h1);
    checkOutput("overrun8 valid held", {31'h0, rxValid8}, 32'h1);
    checkOutput("overrun8 kept old word", {24'h0, rxData8}, 32'h11);
    rxExp8.push_back(32'h11);
    setReady(8, 1'b1);
    drain(8);
    o0 = ovrCnt16;
    csAssert(16);
    spiShift(16, 16, 16, 32'h0011, got);
    spiShift(16, 16, 16, 32'h0022, got);
    csRelease(16);
    checkOutput("overrun16 pulses", ovrCnt16 - o0, 32'h1);
    checkOutput("overrun16 took new word", {16'h0, rxData16}, 32'h0022);
    rxExp16.push_back(32'h0022);
    setReady(16, 1'b1);
    drain(16);

    // No TX word over a 2-byte mode-3 frame
    setMode(MODE3);
    u0 = undCnt8;
    rxExp8.push_back(32'h12);
    rxExp8.push_back(32'h34);
    csAssert(8);
    spiShift(8, 16, 16, 32'h1234, got);
    csRelease(8);
    drain(8);
    checkOutput("underrun pulses", undCnt8 - u0, 32'h2);
    checkOutput("underrun miso fill", got, 32'hFFFF);

    // CS released after 3 bits, then a clean frame
    setMode(MODE0);
    a0 = abtCnt8;
    csAssert(8);
    spiShift(8, 8, 3, 32'hC0, got);
    csRelease(8);
    checkOutput("abort pulse", abtCnt8 - a0, 32'h1);
    checkOutput("abort no rx valid", {31'h0, rxValid8}, 32'h0);
    rxExp8.push_back(32'h5A);
    csAssert(8);
    spiShift(8, 8, 8, 32'h5A, got);
    csRelease(8);
    drain(8);
    checkOutput("clean frame after abort", abtCnt8 - a0, 32'h1);

    // Reset in the middle of a word
    a0 = abtCnt8;
    csAssert(8);
    spiShift(8, 8, 4, 32'h3C, got);
    loadTx8(8'h77);
    sysRst = 1'b1;
    #1;
    checkOutput("mid-word reset state", stat8(), 32'h0800_0000);
    cs8 = 1'b1;
    #200;
    sysRst = 1'b0;
    #1000;
    rxExp8.push_back(32'h3C);
    csAssert(8);
    spiShift(8, 8, 8, 32'h3C, got);
    csRelease(8);
    drain(8);
    checkOutput("no abort across reset", abtCnt8 - a0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
